// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// InterruptController
//
// Purpose:
//   Prioritised, edge-triggered interrupt controller for a small CPU. Rising
//   edges on the level interrupt lines are latched into a pending register.
//   The lowest-numbered pending source that is enabled in the mask is
//   presented to the control unit. The controller then waits for the CPU to
//   accept the interrupt and to return from the handler before it presents
//   the next one. Source 0 is the watchdog interrupt. Accepting it produces
//   a one-cycle watchdog_clear pulse that restarts the watchdog.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   asynchronous, active-low reset
//   irq_in         in   level interrupt lines (bit 0 = watchdog)
//   mask_we        in   load mask_data into the mask register
//   mask_data      in   new mask value, 1 = source enabled
//   irq_ack        in   CPU accepts the presented interrupt
//   irq_done       in   CPU returned from the interrupt handler
//   irq_request    out  interrupt request to the control unit
//   irq_id         out  index of the requested source (0 while idle)
//   watchdog_clear out  one-cycle pulse after the watchdog irq is accepted
//   pending        out  pending register, unmasked view
//   missed_count   out  (only with INTC_MISSED_COUNT_EN) saturating count
//                       of edges that arrived while already pending
//
// Configuration:
//   INTC_MISSED_COUNT_EN - when defined, adds the missed_count output and
//                          its counter.
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int NUM_SOURCES = 4,
    parameter int ID_WIDTH    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic                   mask_we,
    input  logic [NUM_SOURCES-1:0] mask_data,
    input  logic                   irq_ack,
    input  logic                   irq_done,
    output logic                   irq_request,
    output logic [ID_WIDTH-1:0]    irq_id,
    output logic                   watchdog_clear,
    output logic [NUM_SOURCES-1:0] pending
`ifdef INTC_MISSED_COUNT_EN
    ,
    output logic [7:0]             missed_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SERVICE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NUM_SOURCES-1:0] irq_prev;
    logic [NUM_SOURCES-1:0] mask;
    logic [NUM_SOURCES-1:0] irq_edge;
    logic [NUM_SOURCES-1:0] active;
    logic [NUM_SOURCES-1:0] clear_vec;
    logic [ID_WIDTH-1:0]    lowest_id;
    logic [ID_WIDTH-1:0]    id_next;
    logic                   wd_next;

    // A rising edge is a line that is high now and was low on the previous
    // clock. Only enabled pending sources compete for the request.
    always_comb begin
        irq_edge = irq_in & ~irq_prev;
        active   = pending & mask;
    end

    // The loop scans from the highest index down, so the last write is the
    // lowest enabled pending index. That source has the highest priority.
    always_comb begin
        lowest_id = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (active[i]) begin
                lowest_id = ID_WIDTH'(i);
            end
        end
    end

    // Next-state logic. irq_id is chosen once, when the FSM leaves IDLE.
    // It is then held constant through REQUEST and SERVICE, so changes to
    // the mask or to pending bits cannot alter the interrupt the CPU is
    // handling. Accepting the interrupt clears only the presented source's
    // pending bit. It also arms the watchdog pulse when that source is the
    // watchdog.
    always_comb begin
        state_next = state;
        id_next    = irq_id;
        clear_vec  = '0;
        wd_next    = 1'b0;
        case (state)
            IDLE: begin
                id_next = '0;
                if (|active) begin
                    state_next = REQUEST;
                    id_next    = lowest_id;
                end
            end
            REQUEST: begin
                if (irq_ack) begin
                    state_next = SERVICE;
                    clear_vec  = NUM_SOURCES'(1) << irq_id;
                    wd_next    = (irq_id == '0);
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_next = IDLE;
                    id_next    = '0;
                end
            end
            default: begin
                state_next = IDLE;
                id_next    = '0;
            end
        endcase
    end

    // The request is decoded directly from the state register. Reset
    // therefore removes it immediately, without waiting for a clock edge.
    always_comb begin
        irq_request = (state == REQUEST);
    end

    // State and datapath registers. A new edge is ORed in after the clear.
    // When a set and a clear hit the same bit in one cycle, the bit stays
    // set. irq_prev resets to 0, so a line that is already high when reset
    // releases is seen as an edge on the first clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            irq_prev       <= '0;
            pending        <= '0;
            mask           <= '1;
            irq_id         <= '0;
            watchdog_clear <= 1'b0;
        end else begin
            state          <= state_next;
            irq_prev       <= irq_in;
            pending        <= (pending & ~clear_vec) | irq_edge;
            irq_id         <= id_next;
            watchdog_clear <= wd_next;
            if (mask_we) begin
                mask <= mask_data;
            end
        end
    end

`ifdef INTC_MISSED_COUNT_EN
    // An edge is lost when its source is still pending and is not being
    // accepted in the same cycle. The counter adds at most one per cycle,
    // however many sources lose an edge together, and it stops at 255.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            missed_count <= 8'd0;
        end else if ((|(irq_edge & pending & ~clear_vec)) && (missed_count != 8'hFF)) begin
            missed_count <= missed_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Purpose:
//   Self-checking bench for interrupt_controller (4 sources, 2-bit id).
//   A behavioural model of the controller's rules runs on every rising
//   clock. A compare process checks the DUT against that model on every
//   falling clock. Directed sequences pin the model with hand-computed
//   literal expectations, and a randomized phase then exercises the rest.
//   Define INTC_MISSED_COUNT_EN to also cover the missed_count output.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SVC  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irqIn = 4'b0000;
    logic       maskWe = 1'b0;
    logic [3:0] maskData = 4'b0000;
    logic       irqAck = 1'b0;
    logic       irqDone = 1'b0;
    logic       irqRequest;
    logic [1:0] irqId;
    logic       watchdogClear;
    logic [3:0] pendingOut;
`ifdef INTC_MISSED_COUNT_EN
    logic [7:0] missedCount;
`endif

    int assertCount = 0;
    int failCount   = 0;

    // Behavioural model state: the transaction phase, the source presented
    // to the CPU, and the pending/mask/previous-line images.
    logic [3:0] mPrev   = 4'b0000;
    logic [3:0] mPend   = 4'b0000;
    logic [3:0] mMask   = 4'b1111;
    int         mPhase  = P_IDLE;
    int         mId     = 0;
    bit         mWd     = 1'b0;
    int         mMissed = 0;

    interrupt_controller #(
        .NUM_SOURCES(4),
        .ID_WIDTH   (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .irq_in        (irqIn),
        .mask_we       (maskWe),
        .mask_data     (maskData),
        .irq_ack       (irqAck),
        .irq_done      (irqDone),
        .irq_request   (irqRequest),
        .irq_id        (irqId),
        .watchdog_clear(watchdogClear),
        .pending       (pendingOut)
`ifdef INTC_MISSED_COUNT_EN
        ,
        .missed_count  (missedCount)
`endif
    );

    // Free-running clock with a 10 time-unit period.
    always #5 clock = ~clock;

    // Compares one value, counts the comparison, and reports a failure.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advances the model by one rising clock, using the controller's rules.
    task automatic modelStep();
        logic [3:0] edges;
        logic [3:0] clr;
        bit         nextWd;
        if (!reset) begin
            mPrev   = 4'b0000;
            mPend   = 4'b0000;
            mMask   = 4'b1111;
            mPhase  = P_IDLE;
            mId     = 0;
            mWd     = 1'b0;
            mMissed = 0;
        end else begin
            edges  = irqIn & ~mPrev;
            clr    = 4'b0000;
            nextWd = 1'b0;
            if (mPhase == P_IDLE) begin
                mId = 0;
                for (int i = 0; i < 4; i++) begin
                    if (mPend[i] && mMask[i]) begin
                        mId    = i;
                        mPhase = P_REQ;
                        break;
                    end
                end
            end else if (mPhase == P_REQ) begin
                if (irqAck) begin
                    clr[mId] = 1'b1;
                    nextWd   = (mId == 0);
                    mPhase   = P_SVC;
                end
            end else if (irqDone) begin
                mPhase = P_IDLE;
                mId    = 0;
            end
            if (((edges & mPend & ~clr) != 4'b0000) && (mMissed < 255)) begin
                mMissed++;
            end
            mPend = (mPend & ~clr) | edges;
            if (maskWe) begin
                mMask = maskData;
            end
            mPrev = irqIn;
            mWd   = nextWd;
        end
    endtask

    // The model advances on every rising clock edge.
    initial begin
        forever begin
            @(posedge clock);
            modelStep();
        end
    end

    // Every falling edge, the DUT outputs are checked against the model.
    initial begin
        forever begin
            @(negedge clock);
            checkOutput("model irq_request", 32'(irqRequest), 32'(mPhase == P_REQ));
            checkOutput("model irq_id", 32'(irqId), 32'(mId));
            checkOutput("model watchdog_clear", 32'(watchdogClear), 32'(mWd));
            checkOutput("model pending", 32'(pendingOut), 32'(mPend));
`ifdef INTC_MISSED_COUNT_EN
            checkOutput("model missed_count", 32'(missedCount), 32'(mMissed));
`endif
        end
    end

    // Waits until just after the next falling edge. Inputs driven from here
    // are stable well before the following rising edge.
    task automatic nextCycle();
        @(negedge clock);
        #1;
    endtask

    // Drives one set of input values.
    task automatic applyStimulus(input logic [3:0] inVal, input logic we, input logic [3:0] md,
                                 input logic ack, input logic done);
        irqIn    = inVal;
        maskWe   = we;
        maskData = md;
        irqAck   = ack;
        irqDone  = done;
    endtask

    // Checks that reset has forced every output to zero.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " irq_request"}, 32'(irqRequest), 32'd0);
        checkOutput({tag, " irq_id"}, 32'(irqId), 32'd0);
        checkOutput({tag, " watchdog_clear"}, 32'(watchdogClear), 32'd0);
        checkOutput({tag, " pending"}, 32'(pendingOut), 32'd0);
    endtask

    initial begin
        // Reset state.
        nextCycle();
        checkResetOutputs("reset state");
        nextCycle();
        reset = 1'b1;
        nextCycle();

        // Watchdog interrupt: pending, request, ack, then a one-cycle clear.
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("wd pending set", 32'(pendingOut), 32'h1);
        checkOutput("wd no request yet", 32'(irqRequest), 32'd0);
        nextCycle();
        checkOutput("wd request", 32'(irqRequest), 32'd1);
        checkOutput("wd id", 32'(irqId), 32'd0);
        nextCycle();
        checkOutput("wd request held", 32'(irqRequest), 32'd1);
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        nextCycle();
        checkOutput("wd clear pulse", 32'(watchdogClear), 32'd1);
        checkOutput("wd pending cleared", 32'(pendingOut), 32'h0);
        checkOutput("wd request dropped", 32'(irqRequest), 32'd0);
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("wd clear one cycle", 32'(watchdogClear), 32'd0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("idle after done", 32'(irqRequest), 32'd0);

        // Priority: sources 3 and 1 rise together, so 1 is served first.
        applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("prio pending", 32'(pendingOut), 32'ha);
        nextCycle();
        checkOutput("prio first id", 32'(irqId), 32'd1);
        applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0);
        nextCycle();
        checkOutput("prio pending after ack", 32'(pendingOut), 32'h8);
        applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("prio second request", 32'(irqRequest), 32'd1);
        checkOutput("prio second id", 32'(irqId), 32'd3);
        applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();

        // Masking: source 1 latches but raises no request until it is enabled.
        applyStimulus(4'b0000, 1'b1, 4'b1101, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("masked pending", 32'(pendingOut), 32'h2);
        checkOutput("masked no request", 32'(irqRequest), 32'd0);
        applyStimulus(4'b0010, 1'b1, 4'b1111, 1'b0, 1'b0);
        nextCycle();
        checkOutput("unmask load cycle", 32'(irqRequest), 32'd0);
        applyStimulus(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("unmask request", 32'(irqRequest), 32'd1);
        checkOutput("unmask id", 32'(irqId), 32'd1);
        applyStimulus(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();

        // No new request while in SERVICE, even with a new source pending.
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            checkOutput("service blocks request", 32'(irqRequest), 32'd0);
        end
        checkOutput("service pending 2", 32'(pendingOut[2]), 32'd1);
        applyStimulus(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1);
        nextCycle();
        checkOutput("idle cycle no request", 32'(irqRequest), 32'd0);
        applyStimulus(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("after service request", 32'(irqRequest), 32'd1);
        checkOutput("after service id", 32'(irqId), 32'd2);
        applyStimulus(4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();

        // Reset during REQUEST abandons the transaction without a clear pulse.
        applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("pre-reset request", 32'(irqRequest), 32'd1);
        checkOutput("pre-reset id", 32'(irqId), 32'd3);
        reset  = 1'b0;
        irqAck = 1'b1;
        #1;
        checkResetOutputs("async reset");
        nextCycle();
        checkOutput("reset no wd pulse", 32'(watchdogClear), 32'd0);
        irqAck = 1'b0;
        reset  = 1'b1;
        nextCycle();
        checkOutput("high at release is edge", 32'(pendingOut), 32'h8);
        nextCycle();
        applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();

`ifdef INTC_MISSED_COUNT_EN
        // Repeated edges on a source that is never accepted saturate the count.
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
            nextCycle();
            applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
            nextCycle();
        end
        checkOutput("missed saturates", 32'(missedCount), 32'd255);
        applyStimulus(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        nextCycle();
`endif

        // Randomized phase, checked every cycle by the compare process.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                irqIn = irqIn ^ 4'(1 << $urandom_range(0, 3));
            end
            irqAck   = ($urandom_range(0, 2) == 0);
            irqDone  = ($urandom_range(0, 3) == 0);
            maskWe   = ($urandom_range(0, 15) == 0);
            maskData = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #1;
                checkResetOutputs("random reset");
            end else begin
                reset = 1'b1;
            end
            nextCycle();
        end
        reset = 1'b1;
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_SOURCES, default 4, number of interrupt sources; bit 0 is always the watchdog interruption.
REQ-002 Parameter ID_WIDTH, default 2, width of irq_id; SHALL satisfy 2^ID_WIDTH >= NUM_SOURCES.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 irq_in  input  NUM_SOURCES  level interrupt lines; bit 0 is driven by the watchdog interruption output.
REQ-006 mask_we  input  1  write strobe for the mask register.
REQ-007 mask_data  input  NUM_SOURCES  new mask value; 1 = source enabled.
REQ-008 irq_ack  input  1  CPU accepts the presented interrupt.
REQ-009 irq_done  input  1  CPU signals return from the interrupt handler.
REQ-010 irq_request  output  1  interrupt request to the control unit.
REQ-011 irq_id  output  ID_WIDTH  index of the requested source.
REQ-012 watchdog_clear  output  1  one-cycle active-high pulse, wired to the watchdog's synchronous reset.
REQ-013 pending  output  NUM_SOURCES  current pending register, unmasked view.

Function
REQ-014 Edge detect: irq_prev SHALL register irq_in each cycle; edge = irq_in AND NOT irq_prev.
REQ-015 pending[i] SHALL be set on edge[i] and cleared only on acceptance of source i; a simultaneous set and clear on the same bit SHALL leave the bit set.
REQ-016 Masked sources SHALL still latch pending bits but SHALL NOT raise a request; mask_we SHALL load mask_data on the next edge.
REQ-017 FSM states IDLE, REQUEST, SERVICE.
REQ-018 IDLE: if (pending AND mask) is non-zero, go to REQUEST and latch irq_id = lowest set index (index 0 has the highest priority).
REQ-019 REQUEST: irq_request = 1 and irq_id SHALL stay stable until irq_ack, even if the mask or pending bits change.
REQ-020 REQUEST with irq_ack: go to SERVICE and clear pending[irq_id]; if irq_id == 0, assert watchdog_clear for exactly the next cycle.
REQ-021 SERVICE: irq_request = 0; on irq_done, return to IDLE; no new request SHALL be issued before IDLE is re-entered.
REQ-022 irq_ack outside REQUEST and irq_done outside SERVICE SHALL be ignored.
REQ-023 Latency: irq_in rising, sampled at edge N -> pending set after edge N -> irq_request high after edge N+1.
REQ-024 irq_id SHALL be 0 whenever the FSM is in IDLE.

Reset
REQ-025 reset low SHALL immediately force: state IDLE, pending 0, irq_prev 0, mask all ones, irq_request 0, irq_id 0, watchdog_clear 0.
REQ-026 reset asserted mid-REQUEST or mid-SERVICE SHALL abandon the transaction without emitting watchdog_clear.
REQ-027 A source already high when reset releases SHALL register as an edge in the first cycle after release.

Configuration
REQ-028 Macro INTC_MISSED_COUNT_EN, when defined, SHALL add output missed_count (8 bits): it increments when edge[i] occurs while pending[i] is already set and not being cleared that cycle, saturates at 255, resets to 0, and counts at most +1 per cycle.
REQ-029 Without INTC_MISSED_COUNT_EN, the port and the counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Release reset, then raise irq_in[0] at cycle 5 -> pending=0001 after cycle 5, irq_request=1 with irq_id=0 after cycle 6; irq_ack at cycle 8 -> watchdog_clear=1 during cycle 9 only, pending=0000.
REQ-031 Raise irq_in[3] and irq_in[1] in the same cycle -> irq_id=1 first; after ack and done, irq_id=3 on the next request.
REQ-032 mask_data=1101, then raise irq_in[1] -> pending[1]=1 and no request; write mask=1111 -> request with irq_id=1 one cycle later.
REQ-033 In SERVICE, raise irq_in[2] and hold irq_done low for 10 cycles -> irq_request stays 0; irq_done -> request irq_id=2 after the IDLE cycle.
REQ-034 Pull reset low during REQUEST -> outputs are 0 immediately; no watchdog_clear pulse.
REQ-035 With INTC_MISSED_COUNT_EN, toggle irq_in[2] 300 times with ack withheld -> missed_count=255.
